// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: register index width, ALU opcodes and operand selects.
package riscv_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [3:0] {
      AluAdd    = 4'd0,
      AluSub    = 4'd1,
      AluSll    = 4'd2,
      AluSlt    = 4'd3,
      AluSltu   = 4'd4,
      AluXor    = 4'd5,
      AluSrl    = 4'd6,
      AluSra    = 4'd7,
      AluOr     = 4'd8,
      AluAnd    = 4'd9,
      AluLui    = 4'd10,
      AluAuipc  = 4'd11,
      AluRsvd12 = 4'd12,
      AluRsvd13 = 4'd13,
      AluRsvd14 = 4'd14,
      AluRsvd15 = 4'd15
   } alu_op_t;

   typedef enum logic {
      OpASelRs1 = 1'b0,
      OpASelPc  = 1'b1
   } op_a_sel_e;

   typedef enum logic {
      OpBSelRs2 = 1'b0,
      OpBSelImm = 1'b1
   } op_b_sel_e;

endpackage

// File: rtl/riscv_fwd_mux.sv
// Operand forwarding mux: picks the youngest matching bypass source, else register-file data.
// x0 always reads as zero. pend reports that the winning source has no data yet.
module riscv_fwd_mux
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_BYP = 2
) (
   input  logic [REG_IDX_W-1:0]         rs_addr,
   input  logic [XLEN-1:0]              rf_data,
   input  logic [NUM_BYP-1:0]           byp_valid,
   input  logic [NUM_BYP-1:0]           byp_pend,
   input  logic [REG_IDX_W*NUM_BYP-1:0] byp_rd,
   input  logic [XLEN*NUM_BYP-1:0]      byp_data,
   output logic [XLEN-1:0]              op_data,
   output logic                         pend
);

   logic found;

   // Priority scan from source 0; the first hit shadows all older sources.
   always_comb begin
      op_data = rf_data;
      pend    = 1'b0;
      found   = 1'b0;
      if (rs_addr == '0) begin
         op_data = '0;
      end else begin
         for (int i = 0; i < int'(NUM_BYP); i++) begin
            if (!found && byp_valid[i] && (byp_rd[i*REG_IDX_W +: REG_IDX_W] == rs_addr)) begin
               found   = 1'b1;
               op_data = byp_data[i*XLEN +: XLEN];
               pend    = byp_pend[i];
            end
         end
      end
   end

endmodule

// File: rtl/riscv_ex1_opfetch_stage.sv
// EX1 operand-fetch stage: RF read, forwarding, load-use stall and operand A/B selection,
// with a valid/ready output register and a saturating hazard-stall counter.
module riscv_ex1_opfetch_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_BYP = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid,
   output logic                         id_ready,
   input  logic [XLEN-1:0]              id_pc,
   input  logic [REG_IDX_W-1:0]         id_rs1_addr,
   input  logic [REG_IDX_W-1:0]         id_rs2_addr,
   input  logic [REG_IDX_W-1:0]         id_rd_addr,
   input  logic [XLEN-1:0]              id_imm,
   input  logic [3:0]                   id_alu_op,
   input  logic                         id_op_a_sel,
   input  logic                         id_op_b_sel,
   output logic [REG_IDX_W-1:0]         rf_rs1_addr,
   output logic [REG_IDX_W-1:0]         rf_rs2_addr,
   input  logic [XLEN-1:0]              rf_rs1_data,
   input  logic [XLEN-1:0]              rf_rs2_data,
   input  logic [NUM_BYP-1:0]           byp_valid,
   input  logic [NUM_BYP-1:0]           byp_pend,
   input  logic [REG_IDX_W*NUM_BYP-1:0] byp_rd,
   input  logic [XLEN*NUM_BYP-1:0]      byp_data,
   input  logic                         flush,
   output logic                         ex1_valid,
   input  logic                         ex1_ready,
   output logic [XLEN-1:0]              ex1_pc,
   output logic [XLEN-1:0]              ex1_op_a,
   output logic [XLEN-1:0]              ex1_op_b,
   output logic [XLEN-1:0]              ex1_rs2_data,
   output logic [XLEN-1:0]              ex1_imm,
   output logic [REG_IDX_W-1:0]         ex1_rd_addr,
   output logic [3:0]                   ex1_alu_op,
   output logic [CNT_W-1:0]             hazard_stall_cnt
);

   logic [XLEN-1:0]      fwd_rs1, fwd_rs2;
   logic                 pend_rs1, pend_rs2;
   logic                 hazard, accept;
   logic [XLEN-1:0]      op_a_d, op_b_d;

   logic                 valid_q;
   logic [XLEN-1:0]      pc_q, op_a_q, op_b_q, rs2_q, imm_q;
   logic [REG_IDX_W-1:0] rd_q;
   alu_op_t              alu_q;
   logic [CNT_W-1:0]     cnt_q;

   assign rf_rs1_addr = id_rs1_addr;
   assign rf_rs2_addr = id_rs2_addr;

   riscv_fwd_mux #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_fwd_rs1 (
      .rs_addr   (id_rs1_addr),
      .rf_data   (rf_rs1_data),
      .byp_valid (byp_valid),
      .byp_pend  (byp_pend),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .op_data   (fwd_rs1),
      .pend      (pend_rs1)
   );

   riscv_fwd_mux #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_fwd_rs2 (
      .rs_addr   (id_rs2_addr),
      .rf_data   (rf_rs2_data),
      .byp_valid (byp_valid),
      .byp_pend  (byp_pend),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .op_data   (fwd_rs2),
      .pend      (pend_rs2)
   );

   // Handshake and operand selection; both operands gate the stall regardless of op_sel.
   always_comb begin
      hazard   = pend_rs1 | pend_rs2;
      id_ready = !hazard && (!valid_q || ex1_ready);
      accept   = id_valid && id_ready && !flush;
      op_a_d   = (op_a_sel_e'(id_op_a_sel) == OpASelPc)  ? id_pc  : fwd_rs1;
      op_b_d   = (op_b_sel_e'(id_op_b_sel) == OpBSelImm) ? id_imm : fwd_rs2;
   end

   // Output valid: flush kills, accept loads, downstream take drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
      end else if (ex1_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Payload register, loaded only on accept and otherwise held.
   always_ff @(posedge clk) begin
      if (accept) begin
         pc_q   <= id_pc;
         op_a_q <= op_a_d;
         op_b_q <= op_b_d;
         rs2_q  <= fwd_rs2;
         imm_q  <= id_imm;
         rd_q   <= id_rd_addr;
         alu_q  <= alu_op_t'(id_alu_op);
      end
   end

   // Saturating count of cycles where a live ID instruction is held by a load-use hazard.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (id_valid && hazard && !flush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign ex1_valid        = valid_q;
   assign ex1_pc           = pc_q;
   assign ex1_op_a         = op_a_q;
   assign ex1_op_b         = op_b_q;
   assign ex1_rs2_data     = rs2_q;
   assign ex1_imm          = imm_q;
   assign ex1_rd_addr      = rd_q;
   assign ex1_alu_op       = alu_q;
   assign hazard_stall_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_ex1_opfetch_stage.sv
// Scoreboard bench for the EX1 operand-fetch stage. A second instance with CNT_W=2 shares
// all inputs so counter saturation can be observed alongside the normal run.
module tb_riscv_ex1_opfetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic        id_ready, id_ready2;
   logic [31:0] id_pc, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [3:0]  id_alu_op;
   logic        id_op_a_sel, id_op_b_sel;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr, rf_rs1_addr2, rf_rs2_addr2;
   logic [31:0] rf_rs1_data, rf_rs2_data;
   logic [1:0]  byp_valid, byp_pend;
   logic [9:0]  byp_rd;
   logic [63:0] byp_data;
   logic        flush;
   logic        ex1_valid, ex1_valid2;
   logic        ex1_ready;
   logic [31:0] ex1_pc, ex1_op_a, ex1_op_b, ex1_rs2_data, ex1_imm;
   logic [31:0] ex1_pc2, ex1_op_a2, ex1_op_b2, ex1_rs2_data2, ex1_imm2;
   logic [4:0]  ex1_rd_addr, ex1_rd_addr2;
   logic [3:0]  ex1_alu_op, ex1_alu_op2;
   logic [15:0] cnt;
   logic [1:0]  cnt2;

   typedef struct {
      logic [31:0] pc, a, b, s, imm;
      logic [4:0]  rd;
      logic [3:0]  alu;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   riscv_ex1_opfetch_stage #(.XLEN(32), .NUM_BYP(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_imm(id_imm), .id_alu_op(id_alu_op), .id_op_a_sel(id_op_a_sel),
      .id_op_b_sel(id_op_b_sel), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .byp_valid(byp_valid),
      .byp_pend(byp_pend), .byp_rd(byp_rd), .byp_data(byp_data), .flush(flush),
      .ex1_valid(ex1_valid), .ex1_ready(ex1_ready), .ex1_pc(ex1_pc), .ex1_op_a(ex1_op_a),
      .ex1_op_b(ex1_op_b), .ex1_rs2_data(ex1_rs2_data), .ex1_imm(ex1_imm),
      .ex1_rd_addr(ex1_rd_addr), .ex1_alu_op(ex1_alu_op), .hazard_stall_cnt(cnt)
   );

   riscv_ex1_opfetch_stage #(.XLEN(32), .NUM_BYP(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready2), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_imm(id_imm), .id_alu_op(id_alu_op), .id_op_a_sel(id_op_a_sel),
      .id_op_b_sel(id_op_b_sel), .rf_rs1_addr(rf_rs1_addr2), .rf_rs2_addr(rf_rs2_addr2),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .byp_valid(byp_valid),
      .byp_pend(byp_pend), .byp_rd(byp_rd), .byp_data(byp_data), .flush(flush),
      .ex1_valid(ex1_valid2), .ex1_ready(ex1_ready), .ex1_pc(ex1_pc2), .ex1_op_a(ex1_op_a2),
      .ex1_op_b(ex1_op_b2), .ex1_rs2_data(ex1_rs2_data2), .ex1_imm(ex1_imm2),
      .ex1_rd_addr(ex1_rd_addr2), .ex1_alu_op(ex1_alu_op2), .hazard_stall_cnt(cnt2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] alu,
                        input logic asel, input logic bsel);
      id_valid    = 1'b1;
      id_pc       = pc;
      id_rs1_addr = rs1;
      id_rs2_addr = rs2;
      id_rd_addr  = rd;
      id_imm      = imm;
      id_alu_op   = alu;
      id_op_a_sel = asel;
      id_op_b_sel = bsel;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic [31:0] imm, input logic [4:0] rd,
                       input logic [3:0] alu);
      exp_t e;
      e.pc = pc; e.a = a; e.b = b; e.s = s; e.imm = imm; e.rd = rd; e.alu = alu;
      exp_q.push_back(e);
   endtask

   // Output monitor: every EX2 handshake retires the oldest expected instruction.
   always @(negedge clk) begin
      if (rst === 1'b0 && ex1_valid === 1'b1 && ex1_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_pc",   64'(ex1_pc),       64'(mon_e.pc));
            check("out_op_a", 64'(ex1_op_a),     64'(mon_e.a));
            check("out_op_b", 64'(ex1_op_b),     64'(mon_e.b));
            check("out_rs2",  64'(ex1_rs2_data), 64'(mon_e.s));
            check("out_imm",  64'(ex1_imm),      64'(mon_e.imm));
            check("out_rd",   64'(ex1_rd_addr),  64'(mon_e.rd));
            check("out_alu",  64'(ex1_alu_op),   64'(mon_e.alu));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex1_ready = 1'b1;
      id_pc = '0; id_imm = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
      id_alu_op = '0; id_op_a_sel = 1'b0; id_op_b_sel = 1'b0;
      rf_rs1_data = '0; rf_rs2_data = '0;
      byp_valid = '0; byp_pend = '0; byp_rd = '0; byp_data = '0;

      // Reset
      step(); step();
      check("rst_valid", 64'(ex1_valid), 64'd0);
      check("rst_cnt",   64'(cnt),       64'd0);
      check("rst_cnt2",  64'(cnt2),      64'd0);
      rst = 1'b0;

      // Stream of 4, no bypass, B = imm
      for (int k = 0; k < 4; k++) begin
         issue(32'h100 + 32'(4*k), 5'(k+1), 5'(k+2), 5'(k+3), 32'h10 + 32'(k), 4'(k), 1'b0, 1'b1);
         rf_rs1_data = 32'h1000 + 32'(k);
         rf_rs2_data = 32'h2000 + 32'(k);
         push(id_pc, rf_rs1_data, id_imm, rf_rs2_data, id_imm, id_rd_addr, id_alu_op);
         #1 check("stream_ready", 64'(id_ready), 64'd1);
         step();
         check("stream_valid", 64'(ex1_valid), 64'd1);
      end
      id_valid = 1'b0;
      step();
      check("stream_drain", 64'(ex1_valid), 64'd0);

      // Forward priority: both sources match, source 0 wins
      issue(32'h200, 5'd5, 5'd0, 5'd9, 32'h0, 4'd1, 1'b0, 1'b0);
      rf_rs1_data = 32'hAAAA; rf_rs2_data = 32'hBBBB;
      byp_valid = 2'b11; byp_rd = {5'd5, 5'd5}; byp_data = {32'h22, 32'h11};
      push(32'h200, 32'h11, 32'h0, 32'h0, 32'h0, 5'd9, 4'd1);
      step();
      // Only the older source live; rs2 also forwarded
      issue(32'h204, 5'd5, 5'd5, 5'd10, 32'h0, 4'd2, 1'b0, 1'b0);
      byp_valid = 2'b10;
      push(32'h204, 32'h22, 32'h22, 32'h22, 32'h0, 5'd10, 4'd2);
      step();
      // x0 ignores rf and a bypass targeting x0
      issue(32'h208, 5'd0, 5'd6, 5'd11, 32'h0, 4'd3, 1'b0, 1'b0);
      rf_rs1_data = 32'hDEAD; rf_rs2_data = 32'h66;
      byp_valid = 2'b01; byp_rd = {5'd0, 5'd0}; byp_data = {32'h0, 32'h55};
      push(32'h208, 32'h0, 32'h66, 32'h66, 32'h0, 5'd11, 4'd3);
      step();
      id_valid = 1'b0; byp_valid = '0;
      step();

      // Load-use on rs2: 3 stall cycles
      issue(32'h300, 5'd1, 5'd7, 5'd12, 32'h0, 4'd4, 1'b0, 1'b0);
      rf_rs1_data = 32'h111; rf_rs2_data = 32'h777;
      byp_valid = 2'b01; byp_pend = 2'b01; byp_rd = {5'd0, 5'd7}; byp_data = '0;
      for (int c = 0; c < 3; c++) begin
         #1 check("lu_ready", 64'(id_ready), 64'd0);
         step();
      end
      check("lu_cnt",  64'(cnt),  64'd3);
      check("lu_cnt2", 64'(cnt2), 64'd3);
      byp_pend = 2'b00; byp_data = {32'h0, 32'h99};
      push(32'h300, 32'h111, 32'h99, 32'h99, 32'h0, 5'd12, 4'd4);
      #1 check("lu_release", 64'(id_ready), 64'd1);
      step();
      id_valid = 1'b0; byp_valid = '0;
      step();

      // Saturation: 5 more stall cycles
      issue(32'h340, 5'd7, 5'd0, 5'd13, 32'h0, 4'd5, 1'b0, 1'b0);
      byp_valid = 2'b01; byp_pend = 2'b01; byp_rd = {5'd0, 5'd7};
      for (int c = 0; c < 5; c++) step();
      check("sat_cnt",  64'(cnt),  64'd8);
      check("sat_cnt2", 64'(cnt2), 64'd3);
      id_valid = 1'b0; byp_valid = '0; byp_pend = '0;
      step();

      // Back-pressure: hold A for 4 cycles with B waiting
      ex1_ready = 1'b0;
      issue(32'h400, 5'd2, 5'd3, 5'd14, 32'h44, 4'd6, 1'b0, 1'b1);
      rf_rs1_data = 32'hA1; rf_rs2_data = 32'hA2;
      push(32'h400, 32'hA1, 32'h44, 32'hA2, 32'h44, 5'd14, 4'd6);
      step();
      issue(32'h404, 5'd4, 5'd5, 5'd15, 32'h48, 4'd7, 1'b1, 1'b0);
      rf_rs1_data = 32'hB1; rf_rs2_data = 32'hB2;
      for (int c = 0; c < 4; c++) begin
         #1 check("bp_ready", 64'(id_ready), 64'd0);
         check("bp_valid", 64'(ex1_valid), 64'd1);
         check("bp_pc",    64'(ex1_pc),    64'h400);
         check("bp_op_a",  64'(ex1_op_a),  64'hA1);
         step();
      end
      check("bp_cnt", 64'(cnt), 64'd8);
      ex1_ready = 1'b1;
      push(32'h404, 32'h404, 32'hB2, 32'hB2, 32'h48, 5'd15, 4'd7);
      #1 check("bp_ready_rel", 64'(id_ready), 64'd1);
      step();
      check("bp_nobubble", 64'(ex1_valid), 64'd1);
      check("bp_b_pc",     64'(ex1_pc),    64'h404);
      id_valid = 1'b0;
      step();

      // Flush with held C and incoming D under a hazard
      ex1_ready = 1'b0;
      issue(32'h500, 5'd1, 5'd2, 5'd16, 32'h0, 4'd8, 1'b0, 1'b0);
      push(32'h500, 32'hB1, 32'hB2, 32'hB2, 32'h0, 5'd16, 4'd8);
      step();
      issue(32'h504, 5'd9, 5'd0, 5'd17, 32'h0, 4'd9, 1'b0, 1'b0);
      flush = 1'b1; byp_valid = 2'b01; byp_pend = 2'b01; byp_rd = {5'd0, 5'd9};
      step();
      check("fl_valid", 64'(ex1_valid), 64'd0);
      check("fl_cnt",   64'(cnt),       64'd8);
      check("fl_cnt2",  64'(cnt2),      64'd3);
      flush = 1'b0; id_valid = 1'b0; byp_valid = '0; byp_pend = '0; ex1_ready = 1'b1;
      void'(exp_q.pop_front());  // C was killed, never delivered
      step(); step();
      check("fl_no_capture", 64'(ex1_valid), 64'd0);

      // Reset mid-stall
      issue(32'h600, 5'd9, 5'd0, 5'd18, 32'h0, 4'd0, 1'b0, 1'b0);
      byp_valid = 2'b01; byp_pend = 2'b01; byp_rd = {5'd0, 5'd9};
      step(); step();
      check("ms_cnt", 64'(cnt), 64'd10);
      rst = 1'b1;
      step();
      check("ms_rst_cnt",   64'(cnt),       64'd0);
      check("ms_rst_valid", 64'(ex1_valid), 64'd0);
      rst = 1'b0; id_valid = 1'b0; byp_valid = '0; byp_pend = '0;
      step();

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
